// File: rtl/id_operand_stage_if.sv
// Upstream/downstream handshake bundle of the decode-side operand stage.
// The stage connects through the slave modport, its environment through master.
interface id_operand_stage_if #(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int PAYLOAD_W = 64
);
  logic                 in_valid;
  logic                 in_allow_in;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [AW-1:0]        in_rs1;
  logic [AW-1:0]        in_rs2;
  logic                 in_use_rs1;
  logic                 in_use_rs2;
  logic                 in_early;
  logic                 out_valid;
  logic                 out_allow_in;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [XLEN-1:0]      out_op1;
  logic [XLEN-1:0]      out_op2;

  modport slave (
    input  in_valid, in_payload, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_early,
    input  out_allow_in,
    output in_allow_in, out_valid, out_payload, out_op1, out_op2
  );

  modport master (
    output in_valid, in_payload, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_early,
    output out_allow_in,
    input  in_allow_in, out_valid, out_payload, out_op1, out_op2
  );
endinterface

// File: rtl/id_operand_stage.sv
// Operand collection stage between IF and EX: head + skid entry, RF/bypass resolution, flush.
// Define ID_STALL_CNT_EN to build the saturating hazard stall counter; otherwise stall_cnt is 0.
module id_operand_stage #(
  parameter int                 XLEN       = 32,
  parameter int                 AW         = 5,
  parameter int                 PAYLOAD_W  = 64,
  parameter int                 NUM_FWD    = 3,
  parameter logic [NUM_FWD-1:0] EARLY_MASK = {NUM_FWD{1'b0}},
  parameter int                 CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  id_operand_stage_if.slave       bus,
  output logic [AW-1:0]           rf_raddr1,
  output logic [AW-1:0]           rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]      fwd_addr_valid,
  input  logic [NUM_FWD-1:0]      fwd_data_valid,
  input  logic [NUM_FWD*AW-1:0]   fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef struct packed {
    logic                 valid;
    logic [PAYLOAD_W-1:0] payload;
    logic [AW-1:0]        rs1;
    logic [AW-1:0]        rs2;
    logic                 use_rs1;
    logic                 use_rs2;
    logic                 early;
  } entry_t;

  entry_t          head_q, skid_q, head_d, skid_d, in_entry;
  logic            allow_q;
  logic            in_xfer, fire, hazard, out_valid;
  logic [XLEN:0]   res1, res2;

  // Returns {hazard, value}; the lowest-index matching bypass source wins.
  function automatic logic [XLEN:0] resolve(
    input logic                    use_op,
    input logic [AW-1:0]           rs,
    input logic [XLEN-1:0]         rf_data,
    input logic                    early,
    input logic [NUM_FWD-1:0]      av,
    input logic [NUM_FWD-1:0]      dv,
    input logic [NUM_FWD*AW-1:0]   fa,
    input logic [NUM_FWD*XLEN-1:0] fd
  );
    logic [XLEN:0] res;
    logic          found;
    res   = {1'b0, rf_data};
    found = 1'b0;
    if (!use_op || rs == '0) begin
      res = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && av[i] && fa[i*AW +: AW] == rs) begin
          found = 1'b1;
          if (!dv[i] || (early && !EARLY_MASK[i]))
            res = {1'b1, {XLEN{1'b0}}};
          else
            res = {1'b0, fd[i*XLEN +: XLEN]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    in_entry.valid   = 1'b1;
    in_entry.payload = bus.in_payload;
    in_entry.rs1     = bus.in_rs1;
    in_entry.rs2     = bus.in_rs2;
    in_entry.use_rs1 = bus.in_use_rs1;
    in_entry.use_rs2 = bus.in_use_rs2;
    in_entry.early   = bus.in_early;
  end

  always_comb begin
    res1 = resolve(head_q.use_rs1, head_q.rs1, rf_rdata1, head_q.early,
                   fwd_addr_valid, fwd_data_valid, fwd_addr, fwd_data);
    res2 = resolve(head_q.use_rs2, head_q.rs2, rf_rdata2, head_q.early,
                   fwd_addr_valid, fwd_data_valid, fwd_addr, fwd_data);
  end

  assign hazard    = res1[XLEN] | res2[XLEN];
  assign out_valid = head_q.valid & ~hazard & ~flush;
  assign in_xfer   = bus.in_valid & allow_q;
  assign fire      = out_valid & bus.out_allow_in;

  // Skid only ever fills while head is stalled, so head empty implies skid empty.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      head_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (fire && skid_q.valid) begin
      head_d = skid_q;
      if (in_xfer)
        skid_d = in_entry;
      else
        skid_d.valid = 1'b0;
    end else if (!head_q.valid || fire) begin
      head_d       = in_entry;
      head_d.valid = in_xfer;
    end else if (in_xfer) begin
      skid_d = in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q.valid <= 1'b0;
      skid_q.valid <= 1'b0;
      allow_q      <= 1'b1;
    end else begin
      head_q  <= head_d;
      skid_q  <= skid_d;
      allow_q <= ~skid_d.valid;
    end
  end

  assign bus.in_allow_in = allow_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_payload = head_q.payload;
  assign bus.out_op1     = res1[XLEN-1:0];
  assign bus.out_op2     = res2[XLEN-1:0];
  assign rf_raddr1       = head_q.rs1;
  assign rf_raddr2       = head_q.rs2;

`ifdef ID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst)
      stall_q <= '0;
    else if (head_q.valid && hazard && !flush && stall_q != {CNT_W{1'b1}})
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: resolution vector table plus handshake, skid, flush and reset sequences.
// Expected stall count follows whether ID_STALL_CNT_EN is defined for the build.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_use_rs1, in_use_rs2, in_early, out_allow_in;
  logic [63:0] in_payload;
  logic [4:0]  in_rs1, in_rs2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  fwd_addr_valid, fwd_data_valid;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic [4:0]  raddr1_a, raddr2_a, raddr1_b, raddr2_b;
  logic [31:0] stall_a, stall_b;
  int          total = 0;
  int          bad   = 0;

`ifdef ID_STALL_CNT_EN
  localparam logic [31:0] STALL_EXP = 32'd3;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  id_operand_stage_if #(.XLEN(32), .AW(5), .PAYLOAD_W(64)) bus_a ();
  id_operand_stage_if #(.XLEN(32), .AW(5), .PAYLOAD_W(64)) bus_b ();

  assign bus_a.in_valid = in_valid;      assign bus_b.in_valid = in_valid;
  assign bus_a.in_payload = in_payload;  assign bus_b.in_payload = in_payload;
  assign bus_a.in_rs1 = in_rs1;          assign bus_b.in_rs1 = in_rs1;
  assign bus_a.in_rs2 = in_rs2;          assign bus_b.in_rs2 = in_rs2;
  assign bus_a.in_use_rs1 = in_use_rs1;  assign bus_b.in_use_rs1 = in_use_rs1;
  assign bus_a.in_use_rs2 = in_use_rs2;  assign bus_b.in_use_rs2 = in_use_rs2;
  assign bus_a.in_early = in_early;      assign bus_b.in_early = in_early;
  assign bus_a.out_allow_in = out_allow_in;
  assign bus_b.out_allow_in = out_allow_in;

  id_operand_stage #(.XLEN(32), .AW(5), .PAYLOAD_W(64), .NUM_FWD(3),
                     .EARLY_MASK(3'b100), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_a),
    .rf_raddr1(raddr1_a), .rf_raddr2(raddr2_a),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_addr_valid(fwd_addr_valid), .fwd_data_valid(fwd_data_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .stall_cnt(stall_a)
  );

  id_operand_stage #(.XLEN(32), .AW(5), .PAYLOAD_W(64), .NUM_FWD(3),
                     .EARLY_MASK(3'b101), .CNT_W(32)) dut_early (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_b),
    .rf_raddr1(raddr1_b), .rf_raddr2(raddr2_b),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_addr_valid(fwd_addr_valid), .fwd_data_valid(fwd_data_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .stall_cnt(stall_b)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2, early;
    logic [2:0]  av, dv;
    logic [14:0] fa;
    logic [95:0] fd;
    logic [31:0] rf1, rf2;
    logic        exp_valid;
    logic [31:0] exp_op1, exp_op2;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    flush = 1'b0; in_valid = 1'b0; in_payload = '0; in_rs1 = '0; in_rs2 = '0;
    in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_early = 1'b0; out_allow_in = 1'b0;
    rf_rdata1 = '0; rf_rdata2 = '0; fwd_addr_valid = '0; fwd_data_valid = '0;
    fwd_addr = '0; fwd_data = '0;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input logic [63:0] payload);
    in_valid = 1'b1; in_payload = payload;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_use_rs1 = v.u1; in_use_rs2 = v.u2; in_early = v.early;
    fwd_addr_valid = v.av; fwd_data_valid = v.dv; fwd_addr = v.fa; fwd_data = v.fd;
    rf_rdata1 = v.rf1; rf_rdata2 = v.rf2;
  endtask

  initial begin
    // rs1, rs2, u1, u2, early, av, dv, fa{s2,s1,s0}, fd{s2,s1,s0}, rf1, rf2, exp_valid, op1, op2
    vecs[0] = '{5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 15'd0, 96'd0,
                32'h1111, 32'h2222, 1'b1, 32'h1111, 32'h2222};
    vecs[1] = '{5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 3'b101, 3'b101, {5'd5, 5'd0, 5'd5},
                {32'h22, 32'h0, 32'h11}, 32'h77, 32'h88, 1'b1, 32'h11, 32'h0};
    vecs[2] = '{5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 3'b011, 3'b000, {5'd0, 5'd9, 5'd0},
                96'd0, 32'h5, 32'h6, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{5'd4, 5'd1, 1'b1, 1'b1, 1'b0, 3'b010, 3'b000, {5'd0, 5'd4, 5'd0},
                96'd0, 32'h5, 32'h6, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 3'b011, 3'b010, {5'd0, 5'd8, 5'd8},
                {32'h0, 32'h33, 32'h0}, 32'h5, 32'h6, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{5'd10, 5'd11, 1'b1, 1'b1, 1'b0, 3'b010, 3'b011, {5'd0, 5'd10, 5'd10},
                {32'h0, 32'h55, 32'h44}, 32'hAA, 32'hBB, 1'b1, 32'h55, 32'hBB};
    vecs[6] = '{5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 3'b100, 3'b100, {5'd3, 5'd0, 5'd0},
                {32'h66, 32'h0, 32'h0}, 32'hCC, 32'hDD, 1'b1, 32'h66, 32'h0};
    vecs[7] = '{5'd0, 5'd12, 1'b0, 1'b1, 1'b1, 3'b010, 3'b010, {5'd0, 5'd12, 5'd0},
                {32'h0, 32'h77, 32'h0}, 32'hCC, 32'hDD, 1'b0, 32'h0, 32'h0};
    vecs[8] = '{5'd15, 5'd15, 1'b1, 1'b1, 1'b0, 3'b001, 3'b001, {5'd0, 5'd0, 5'd15},
                {32'h0, 32'h0, 32'h99}, 32'h1, 32'h2, 1'b1, 32'h99, 32'h99};

    clearInputs();
    rst = 1'b0;
    tick();
    tick();
    #1;
    checkOutput("reset_allow_in", 96'(bus_a.in_allow_in), 96'd1);
    checkOutput("reset_out_valid", 96'(bus_a.out_valid), 96'd0);
    checkOutput("reset_stall_cnt", 96'(stall_a), 96'd0);
    checkOutput("reset_b_allow_in", 96'(bus_b.in_allow_in), 96'd1);
    checkOutput("reset_b_stall_cnt", 96'(stall_b), 96'd0);
    rst = 1'b1;

    // Operand resolution table: load one entry with EX blocked, inspect, then flush it away.
    for (int n = 0; n < 9; n++) begin
      applyStimulus(vecs[n], 64'(n + 16'h500));
      tick();
      in_valid = 1'b0;
      #1;
      checkOutput($sformatf("vec%0d_out_valid", n), 96'(bus_a.out_valid), 96'(vecs[n].exp_valid));
      checkOutput($sformatf("vec%0d_raddr", n), 96'({raddr2_a, raddr1_a}), 96'({vecs[n].rs2, vecs[n].rs1}));
      if (vecs[n].exp_valid) begin
        checkOutput($sformatf("vec%0d_op1", n), 96'(bus_a.out_op1), 96'(vecs[n].exp_op1));
        checkOutput($sformatf("vec%0d_op2", n), 96'(bus_a.out_op2), 96'(vecs[n].exp_op2));
        checkOutput($sformatf("vec%0d_payload", n), 96'(bus_a.out_payload), 96'(n + 16'h500));
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end

    // Back-to-back independent instructions with EX always ready.
    doReset();
    out_allow_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_payload = 64'(256 + k); in_rs1 = 5'(k + 1); in_use_rs1 = 1'b1;
      rf_rdata1 = 32'(160 + k);
      #1;
      if (k > 0) begin
        checkOutput($sformatf("b2b%0d_out_valid", k), 96'(bus_a.out_valid), 96'd1);
        checkOutput($sformatf("b2b%0d_payload", k), 96'(bus_a.out_payload), 96'(256 + k - 1));
        checkOutput($sformatf("b2b%0d_raddr1", k), 96'(raddr1_a), 96'(k));
        checkOutput($sformatf("b2b%0d_op1", k), 96'(bus_a.out_op1), 96'(160 + k));
        checkOutput($sformatf("b2b%0d_allow_in", k), 96'(bus_a.in_allow_in), 96'd1);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checkOutput("b2b_last_payload", 96'(bus_a.out_payload), 96'h104);
    tick();
    checkOutput("b2b_drained", 96'(bus_a.out_valid), 96'd0);

    // Operand waits three cycles on an unfinished bypass source.
    doReset();
    out_allow_in = 1'b1;
    in_valid = 1'b1; in_payload = 64'h77; in_rs2 = 5'd7; in_use_rs2 = 1'b1;
    fwd_addr_valid = 3'b010; fwd_addr = {5'd0, 5'd7, 5'd0}; fwd_data_valid = 3'b000;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("stall%0d_out_valid", c), 96'(bus_a.out_valid), 96'd0);
      tick();
    end
    fwd_data_valid = 3'b010; fwd_data = {32'h0, 32'hABCD, 32'h0};
    #1;
    checkOutput("stall_release_valid", 96'(bus_a.out_valid), 96'd1);
    checkOutput("stall_release_op2", 96'(bus_a.out_op2), 96'hABCD);
    checkOutput("stall_cnt", 96'(stall_a), 96'(STALL_EXP));
    tick();
    checkOutput("stall_fired", 96'(bus_a.out_valid), 96'd0);
    checkOutput("stall_cnt_hold", 96'(stall_a), 96'(STALL_EXP));

    // Early-use operand matched on a source not allowed for early use.
    doReset();
    in_valid = 1'b1; in_payload = 64'hE; in_rs1 = 5'd3; in_use_rs1 = 1'b1; in_early = 1'b1;
    fwd_addr_valid = 3'b001; fwd_data_valid = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd3};
    fwd_data = {32'h0, 32'h0, 32'h55}; rf_rdata1 = 32'h99;
    tick();
    in_valid = 1'b0;
    #1;
    checkOutput("early_mask100_held", 96'(bus_a.out_valid), 96'd0);
    checkOutput("early_mask101_valid", 96'(bus_b.out_valid), 96'd1);
    checkOutput("early_mask101_op1", 96'(bus_b.out_op1), 96'h55);
    checkOutput("early_mask101_raddr", 96'({raddr2_b, raddr1_b}), 96'({5'd0, 5'd3}));
    tick();
    checkOutput("early_mask100_still_held", 96'(bus_a.out_valid), 96'd0);
    fwd_addr_valid = 3'b000;
    #1;
    checkOutput("early_release_valid", 96'(bus_a.out_valid), 96'd1);
    checkOutput("early_release_op1", 96'(bus_a.out_op1), 96'h99);

    // Skid fill and drain with EX blocked, then released.
    doReset();
    in_use_rs1 = 1'b1; in_rs1 = 5'd1; rf_rdata1 = 32'h1000;
    in_valid = 1'b1; in_payload = 64'hA;
    tick();
    checkOutput("skid_head_only_allow", 96'(bus_a.in_allow_in), 96'd1);
    checkOutput("skid_head_payload", 96'(bus_a.out_payload), 96'hA);
    in_payload = 64'hB;
    tick();
    checkOutput("skid_full_allow", 96'(bus_a.in_allow_in), 96'd0);
    in_payload = 64'hC;
    tick();
    checkOutput("skid_blocked_allow", 96'(bus_a.in_allow_in), 96'd0);
    checkOutput("skid_blocked_payload", 96'(bus_a.out_payload), 96'hA);
    in_valid = 1'b0; out_allow_in = 1'b1;
    tick();
    checkOutput("skid_second_payload", 96'(bus_a.out_payload), 96'hB);
    checkOutput("skid_second_valid", 96'(bus_a.out_valid), 96'd1);
    checkOutput("skid_drained_allow", 96'(bus_a.in_allow_in), 96'd1);
    tick();
    checkOutput("skid_empty", 96'(bus_a.out_valid), 96'd0);

    // Flush with both entries full and a new entry offered.
    doReset();
    in_valid = 1'b1; in_payload = 64'hA;
    tick();
    in_payload = 64'hB;
    tick();
    #1;
    checkOutput("flush_pre_allow", 96'(bus_a.in_allow_in), 96'd0);
    flush = 1'b1; in_payload = 64'hC; out_allow_in = 1'b1;
    #1;
    checkOutput("flush_gates_valid", 96'(bus_a.out_valid), 96'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("flush_out_valid", 96'(bus_a.out_valid), 96'd0);
    checkOutput("flush_allow_in", 96'(bus_a.in_allow_in), 96'd1);
    tick();
    checkOutput("flush_no_ghost", 96'(bus_a.out_valid), 96'd0);

    // Same with reset instead of flush, after some hazard cycles.
    doReset();
    in_valid = 1'b1; in_payload = 64'hA; in_rs1 = 5'd5; in_use_rs1 = 1'b1;
    fwd_addr_valid = 3'b100; fwd_addr = {5'd5, 5'd0, 5'd0}; fwd_data_valid = 3'b000;
    tick();
    in_payload = 64'hB;
    tick();
    tick();
    rst = 1'b0; in_payload = 64'hC; out_allow_in = 1'b1;
    tick();
    rst = 1'b1; in_valid = 1'b0; fwd_addr_valid = 3'b000;
    #1;
    checkOutput("rst_out_valid", 96'(bus_a.out_valid), 96'd0);
    checkOutput("rst_allow_in", 96'(bus_a.in_allow_in), 96'd1);
    checkOutput("rst_stall_cnt", 96'(stall_a), 96'd0);
    tick();
    checkOutput("rst_no_ghost", 96'(bus_a.out_valid), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised decode-side operand collection stage for the pipelined RISC-V core, sitting between IF and EX. It buffers one in-flight instruction plus one skid entry. It resolves up to two source operands from the register file or from `NUM_FWD` prioritised bypass sources, and holds the instruction until every operand is valid. Compared with the fixed three-source ID stage, it adds configurable width and source count, early-use restrictions per source, a registered allow-in through a skid buffer, and flush.

## Interface
Parameters:
- `XLEN`, 32, operand width
- `AW`, 5, register address width
- `PAYLOAD_W`, 64, opaque pass-through payload width (instruction and PC)
- `NUM_FWD`, 3, number of bypass sources; index 0 is the youngest and has the highest priority
- `EARLY_MASK`, {NUM_FWD{1'b0}}, bit i set means source i may feed an early-use operand
- `CNT_W`, 32, stall counter width

Ports:
- `clk`  in  1  clock. One clock domain; reset is synchronous and active-low.
- `rst`  in  1  synchronous active-low reset
- `flush`  in  1  discard the head and skid entries
- `in_valid`  in  1  upstream entry valid
- `in_allow_in`  out  1  upstream may transfer; registered
- `in_payload`  in  PAYLOAD_W  pass-through data
- `in_rs1`, `in_rs2`  in  AW  source register addresses
- `in_use_rs1`, `in_use_rs2`  in  1  operand is actually read
- `in_early`  in  1  operands are consumed in this stage (branch or JALR)
- `rf_raddr1`, `rf_raddr2`  out  AW  register file read addresses, taken from the head entry
- `rf_rdata1`, `rf_rdata2`  in  XLEN  combinational register file data
- `fwd_addr_valid`  in  NUM_FWD  source i will write `fwd_addr[i]`
- `fwd_data_valid`  in  NUM_FWD  `fwd_data[i]` is final
- `fwd_addr`  in  NUM_FWD*AW  packed; source i occupies `[i*AW +: AW]`
- `fwd_data`  in  NUM_FWD*XLEN  packed, same layout
- `out_valid`  out  1  head entry ready for EX
- `out_allow_in`  in  1  EX accepts
- `out_payload`  out  PAYLOAD_W  head payload
- `out_op1`, `out_op2`  out  XLEN  resolved operands
- `stall_cnt`  out  CNT_W  hazard stall cycles (only with the macro)

## Operation
Storage:
- Two entries, head and skid, each holding a valid bit, payload, rs1, rs2, use bits and the early bit.

Transfers:
- Input transfer: `in_valid & in_allow_in`.
- Output fire: `out_valid & out_allow_in`.
- Entry movement on an input transfer:
  - Head empty, or head firing with skid empty: the entry goes to head.
  - Otherwise: the entry goes to skid.
- When head fires and skid is valid, skid moves to head in the same cycle. An input transfer in that cycle goes to skid.
- `in_allow_in` next value is `~skid_valid_next`.

Per-operand resolution (operand n of the head):
- Not used, or address 0: the value is 0 and there is no hazard.
- Otherwise, find the lowest index i with `fwd_addr_valid[i]` and an address match.
  - `fwd_data_valid[i]` = 0: hazard.
  - Head early bit set and `EARLY_MASK[i]` = 0: hazard.
  - Neither: the operand is `fwd_data[i]`.
- No match: the operand is `rf_rdataN`.

Output rules:
- `out_valid` = head_valid & ~hazard & ~flush.
- `out_op*` and `out_payload` are don't-care while `out_valid` = 0.

Flush:
- Clears both valid bits on the next edge.
- Any input transfer in a flush cycle is discarded.
- Flush takes priority over every other event.

## Timing
- Reset (`rst`=0 at an edge): head and skid invalid, `in_allow_in`=1, `out_valid`=0, `stall_cnt`=0.
- Latency: an entry accepted at edge N can present `out_valid` in cycle N+1 if it has no hazard.
- Hazard resolution is combinational. `out_valid` rises in the cycle the forwarding bus shows valid data.
- `in_allow_in` drops in the cycle after skid fills and rises in the cycle after skid drains. The upstream never sees a combinational path from `out_allow_in`.
- Throughput: one instruction per cycle when hazard-free with `out_allow_in`=1 steady.
- Reset mid-operation behaves identically to flush plus a counter clear.

## Configuration
- `ID_STALL_CNT_EN` defined:
  - `stall_cnt` increments on each cycle with head_valid & hazard & ~flush.
  - The counter saturates at all-ones and clears on reset.
- `ID_STALL_CNT_EN` undefined:
  - The counter logic is absent and `stall_cnt` is tied to 0.

## Test plan
- Back-to-back independent instructions, `out_allow_in`=1, no forwarding matches -> one fire per cycle, `out_op1`=`rf_rdata1`, `in_allow_in` stays 1.
- Head rs1=5; sources 0 and 2 both address x5 with data valid, data 0x11 and 0x22 -> `out_op1`=0x11.
- Head rs2=7; source 1 has addr_valid=1 and data_valid=0 for 3 cycles, then data 0xABCD -> `out_valid` low 3 cycles, then fires with `out_op2`=0xABCD. With the macro defined, `stall_cnt`=3.
- `EARLY_MASK`=3'b100, `in_early`=1, rs1 matches source 0 with valid data -> held until source 0 deasserts, then takes `rf_rdata1`. The same match with `EARLY_MASK`=3'b101 fires immediately.
- `out_allow_in`=0 with 2 entries sent -> skid fills, `in_allow_in`=0 the next cycle. Then `out_allow_in`=1 -> entries exit in order, `in_allow_in`=1 one cycle after the skid drains.
- Flush with both entries full and `in_valid`=1 -> next cycle `out_valid`=0, `in_allow_in`=1, and the entry offered in the flush cycle never appears. Repeat with `rst`=0 -> same, plus `stall_cnt`=0.
